// File: rtl/sim_halt_pkg.sv
// Shared definitions for the run-control / halt-detection monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sim_halt_pkg;

  // Halt cause codes reported on halt_cause.
  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_ECALL   = 3'd1,
    CAUSE_EBREAK  = 3'd2,
    CAUSE_FAULT   = 3'd3,
    CAUSE_TIMEOUT = 3'd4,
    CAUSE_LOOP    = 3'd5
  } cause_e;

  // Run-control state encoding.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Full instruction words that terminate a run.
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // SYSTEM major opcode.
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Exact match of a SYSTEM instruction: opcode field and the full word.
  function automatic logic is_system_word(input logic [31:0] inst, input logic [31:0] word);
    return (inst[6:0] == OPC_SYSTEM) && (inst == word);
  endfunction

endpackage

// File: rtl/sim_halt_monitor_if.sv
// Core-side observation bus plus halt record outputs of the monitor.
// Latency: n/a (wires only).
// Backpressure: none; the monitor only observes, halt_req is the sole feedback.
interface sim_halt_monitor_if #(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 32,
  parameter int NUM_FAULTS = 3
) ();

  logic [31:0]           inst;
  logic [XLEN-1:0]       pc;
  logic                  valid;
  logic                  stall;
  logic [NUM_FAULTS-1:0] fault;

  logic                  halt_req;
  logic                  done;
  logic [2:0]            halt_cause;
  logic [XLEN-1:0]       halt_pc;
  logic [NUM_FAULTS-1:0] halt_fault_vec;
  logic [CNT_W-1:0]      cycle_count;
  logic [CNT_W-1:0]      instret_count;

  // Core / environment side: presents instructions, consumes the halt record.
  modport master (
    output inst, pc, valid, stall, fault,
    input  halt_req, done, halt_cause, halt_pc, halt_fault_vec, cycle_count, instret_count
  );

  // Monitor side.
  modport slave (
    input  inst, pc, valid, stall, fault,
    output halt_req, done, halt_cause, halt_pc, halt_fault_vec, cycle_count, instret_count
  );

endinterface

// File: rtl/sim_halt_monitor_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Latency: count visible one edge after the enabled cycle.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sim_halt_monitor.sv
// Run-control monitor: counts cycles/retires, detects ECALL/EBREAK/fault/loop/timeout, drains, then halts.
// Latency: halt_req one edge after the event; done DRAIN_CYCLES+1 edges after the event edge.
// Backpressure: none on inputs; halt_req asks the core to stop issuing, DRAIN/HALTED ignore inputs.
module sim_halt_monitor
  import sim_halt_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 100000,
  parameter int DRAIN_CYCLES = 2,
  parameter int LOOP_LIMIT   = 4,
  parameter int NUM_FAULTS   = 3
) (
  input logic               clk,
  input logic               rst,
  sim_halt_monitor_if.slave bus
);

  localparam int DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int LCW = (LOOP_LIMIT > 1) ? $clog2(LOOP_LIMIT) + 1 : 1;

  localparam logic [DCW-1:0] DRAIN_LOAD  = DCW'(DRAIN_CYCLES);
  localparam logic [LCW-1:0] LOOP_HIT    = LCW'((LOOP_LIMIT > 0) ? LOOP_LIMIT - 1 : 0);
  localparam logic [63:0]    TIMEOUT_HIT = 64'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]            state_q, state_d;
  logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [LCW-1:0]        loop_cnt_q, loop_cnt_d;
  logic [XLEN-1:0]       last_pc_q, last_pc_d;
  logic                  last_pc_vld_q, last_pc_vld_d;
  cause_e                cause_q, cause_d;
  logic [XLEN-1:0]       halt_pc_q, halt_pc_d;
  logic [NUM_FAULTS-1:0] fault_vec_q, fault_vec_d;
  logic                  halt_req_q, halt_req_d;
  logic                  done_q, done_d;

  logic [CNT_W-1:0]      cycle_cnt;
  logic [CNT_W-1:0]      instret_cnt;

  logic                  in_run;
  logic                  retire;
  logic                  ev_fault, ev_ecall, ev_ebreak, ev_loop, ev_timeout, ev_any;
  logic [LCW-1:0]        loop_cnt_nxt;
  cause_e                ev_cause;

  // Event detection and priority encoding for the current cycle.
  always_comb begin
    in_run       = (state_q == ST_RUN);
    retire       = bus.valid && !bus.stall;
    loop_cnt_nxt = (last_pc_vld_q && (bus.pc == last_pc_q)) ? loop_cnt_q + LCW'(1) : '0;

    // A fault is taken whenever the slot is valid, even while stalled.
    ev_fault   = in_run && bus.valid && (|bus.fault);
    ev_ecall   = in_run && retire && is_system_word(bus.inst, INST_ECALL);
    ev_ebreak  = in_run && retire && is_system_word(bus.inst, INST_EBREAK);
    ev_loop    = in_run && retire && (LOOP_LIMIT != 0) && (loop_cnt_nxt == LOOP_HIT);
    ev_timeout = in_run && !(ev_fault || ev_ecall || ev_ebreak || ev_loop) &&
                 (TIMEOUT != 0) && (64'(cycle_cnt) == TIMEOUT_HIT);
    ev_any     = ev_fault || ev_ecall || ev_ebreak || ev_loop || ev_timeout;

    ev_cause = CAUSE_NONE;
    if (ev_fault) begin
      ev_cause = CAUSE_FAULT;
    end else if (ev_ecall) begin
      ev_cause = CAUSE_ECALL;
    end else if (ev_ebreak) begin
      ev_cause = CAUSE_EBREAK;
    end else if (ev_loop) begin
      ev_cause = CAUSE_LOOP;
    end else if (ev_timeout) begin
      ev_cause = CAUSE_TIMEOUT;
    end
  end

  // Run-control FSM, halt record capture and self-loop tracking.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    loop_cnt_d    = loop_cnt_q;
    last_pc_d     = last_pc_q;
    last_pc_vld_d = last_pc_vld_q;
    cause_d       = cause_q;
    halt_pc_d     = halt_pc_q;
    fault_vec_d   = fault_vec_q;
    halt_req_d    = halt_req_q;
    // done trails HALTED by one edge so that DRAIN_CYCLES==0 still gives a one-edge gap.
    done_d        = (state_q == ST_HALTED);

    case (state_q)
      ST_RUN: begin
        if (retire) begin
          loop_cnt_d    = loop_cnt_nxt;
          last_pc_d     = bus.pc;
          last_pc_vld_d = 1'b1;
        end
        if (ev_any) begin
          cause_d     = ev_cause;
          halt_pc_d   = bus.pc;
          fault_vec_d = bus.fault;
          halt_req_d  = 1'b1;
          drain_cnt_d = DRAIN_LOAD;
          state_d     = (DRAIN_CYCLES == 0) ? ST_HALTED : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave on the edge where the counter reaches zero.
        if (drain_cnt_q <= DCW'(1)) begin
          drain_cnt_d = '0;
          state_d     = ST_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - DCW'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and record registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      drain_cnt_q   <= '0;
      loop_cnt_q    <= '0;
      last_pc_q     <= '0;
      last_pc_vld_q <= 1'b0;
      cause_q       <= CAUSE_NONE;
      halt_pc_q     <= '0;
      fault_vec_q   <= '0;
      halt_req_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      loop_cnt_q    <= loop_cnt_d;
      last_pc_q     <= last_pc_d;
      last_pc_vld_q <= last_pc_vld_d;
      cause_q       <= cause_d;
      halt_pc_q     <= halt_pc_d;
      fault_vec_q   <= fault_vec_d;
      halt_req_q    <= halt_req_d;
      done_q        <= done_d;
    end
  end

  // Cycle count runs for every RUN cycle including the event cycle.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .en  (in_run),
    .clr (1'b0),
    .cnt (cycle_cnt)
  );

  // A faulting instruction is not retired; ECALL/EBREAK are.
  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk (clk),
    .rst (rst),
    .en  (in_run && retire && !ev_fault),
    .clr (1'b0),
    .cnt (instret_cnt)
  );

  assign bus.halt_req       = halt_req_q;
  assign bus.done           = done_q;
  assign bus.halt_cause     = cause_q;
  assign bus.halt_pc        = halt_pc_q;
  assign bus.halt_fault_vec = fault_vec_q;
  assign bus.cycle_count    = cycle_cnt;
  assign bus.instret_count  = instret_cnt;

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Bench for sim_halt_monitor: directed scenarios plus randomized runs against a behavioural model.
// Two instances: A (TIMEOUT 50, drain 2, 32-bit counters) and B (no timeout, drain 0, 4-bit counters).
module tb_sim_halt_monitor;

  localparam logic [31:0] I_ADDI   = 32'h0010_8093;
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_JAL    = 32'h0000_006f;
  localparam logic [31:0] I_WFI    = 32'h1050_0073;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_checks;
  int n_pass;

  sim_halt_monitor_if #(.XLEN(32), .CNT_W(32), .NUM_FAULTS(3)) bus_a ();
  sim_halt_monitor_if #(.XLEN(32), .CNT_W(4),  .NUM_FAULTS(3)) bus_b ();

  sim_halt_monitor #(
    .XLEN(32), .CNT_W(32), .TIMEOUT(50), .DRAIN_CYCLES(2), .LOOP_LIMIT(4), .NUM_FAULTS(3)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  sim_halt_monitor #(
    .XLEN(32), .CNT_W(4), .TIMEOUT(0), .DRAIN_CYCLES(0), .LOOP_LIMIT(4), .NUM_FAULTS(3)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance parameters as seen by the model.
  function automatic int p_drain(input int id);
    return (id == 0) ? 2 : 0;
  endfunction
  function automatic int p_timeout(input int id);
    return (id == 0) ? 50 : 0;
  endfunction
  function automatic int p_loop(input int id);
    return 4;
  endfunction
  function automatic longint unsigned p_max(input int id);
    return (id == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction

  // Behavioural model state: has an event been seen, and how many edges since then.
  bit              m_ev[2];
  int              m_since[2];
  int              m_cause[2];
  longint unsigned m_pc[2];
  int              m_fv[2];
  longint unsigned m_cyc[2];
  longint unsigned m_ret[2];
  longint unsigned m_last[2];
  bit              m_have_last[2];
  int              m_run[2];

  // Sampled DUT outputs.
  logic [63:0] o_cause, o_pc, o_fv, o_req, o_done, o_cyc, o_ret;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset(input int id);
    m_ev[id] = 0; m_since[id] = 0; m_cause[id] = 0; m_pc[id] = 0; m_fv[id] = 0;
    m_cyc[id] = 0; m_ret[id] = 0; m_last[id] = 0; m_have_last[id] = 0; m_run[id] = 0;
  endtask

  // One clock edge of the reference behaviour, given the inputs present before the edge.
  task automatic model_step(input int id, input logic [31:0] inst, input logic [31:0] pc,
                            input logic v, input logic s, input logic [2:0] f);
    bit ret, ef, ec, eb, lp, to;
    int newrun;
    if (m_ev[id]) begin
      m_since[id]++;
      return;
    end
    ret    = v && !s;
    ef     = v && (f != 3'b000);
    ec     = ret && (inst == I_ECALL);
    eb     = ret && (inst == I_EBREAK);
    // run length = number of consecutive retires at this same pc, including this one
    newrun = (m_have_last[id] && (longint'(pc) == m_last[id])) ? m_run[id] + 1 : 1;
    lp     = ret && (p_loop(id) != 0) && (newrun == p_loop(id));
    to     = !(ef || ec || eb || lp) && (p_timeout(id) != 0) &&
             (m_cyc[id] == longint'(p_timeout(id) - 1));
    if (m_cyc[id] < p_max(id)) m_cyc[id]++;
    if (ret && !ef && (m_ret[id] < p_max(id))) m_ret[id]++;
    if (ret) begin
      m_last[id] = longint'(pc);
      m_have_last[id] = 1;
      m_run[id] = newrun;
    end
    if (ef || ec || eb || lp || to) begin
      m_ev[id]    = 1;
      m_since[id] = 0;
      m_pc[id]    = longint'(pc);
      m_fv[id]    = int'(f);
      m_cause[id] = ef ? 3 : ec ? 1 : eb ? 2 : lp ? 5 : 4;
    end
  endtask

  task automatic sample(input int id);
    if (id == 0) begin
      o_cause = 64'(bus_a.halt_cause);  o_pc  = 64'(bus_a.halt_pc);
      o_fv    = 64'(bus_a.halt_fault_vec); o_req = 64'(bus_a.halt_req);
      o_done  = 64'(bus_a.done);        o_cyc = 64'(bus_a.cycle_count);
      o_ret   = 64'(bus_a.instret_count);
    end else begin
      o_cause = 64'(bus_b.halt_cause);  o_pc  = 64'(bus_b.halt_pc);
      o_fv    = 64'(bus_b.halt_fault_vec); o_req = 64'(bus_b.halt_req);
      o_done  = 64'(bus_b.done);        o_cyc = 64'(bus_b.cycle_count);
      o_ret   = 64'(bus_b.instret_count);
    end
  endtask

  task automatic check_model(input int id, input string ctx);
    sample(id);
    check($sformatf("%s.cause", ctx), o_cause, 64'(m_cause[id]));
    check($sformatf("%s.halt_pc", ctx), o_pc, m_pc[id]);
    check($sformatf("%s.fault_vec", ctx), o_fv, 64'(m_fv[id]));
    check($sformatf("%s.halt_req", ctx), o_req, 64'(m_ev[id]));
    check($sformatf("%s.done", ctx), o_done, 64'(m_ev[id] && (m_since[id] >= p_drain(id) + 1)));
    check($sformatf("%s.cycle", ctx), o_cyc, m_cyc[id]);
    check($sformatf("%s.instret", ctx), o_ret, m_ret[id]);
  endtask

  task automatic set_inputs(input int id, input logic [31:0] inst, input logic [31:0] pc,
                            input logic v, input logic s, input logic [2:0] f);
    if (id == 0) begin
      bus_a.inst = inst; bus_a.pc = pc; bus_a.valid = v; bus_a.stall = s; bus_a.fault = f;
    end else begin
      bus_b.inst = inst; bus_b.pc = pc; bus_b.valid = v; bus_b.stall = s; bus_b.fault = f;
    end
  endtask

  // Present one cycle of inputs, clock it, update the model, compare.
  task automatic drive(input int id, input string ctx, input logic [31:0] inst, input logic [31:0] pc,
                       input logic v, input logic s, input logic [2:0] f);
    set_inputs(id, inst, pc, v, s, f);
    @(posedge clk);
    model_step(id, inst, pc, v, s, f);
    #1;
    check_model(id, ctx);
  endtask

  task automatic idle(input int id, input string ctx);
    drive(id, ctx, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
  endtask

  // Asynchronous reset away from the clock edge; returns with rst released, before the first RUN edge.
  task automatic do_reset(input int id, input string ctx);
    if (id == 0) rst_a = 1'b1; else rst_b = 1'b1;
    #2;
    model_reset(id);
    check_model(id, ctx);
    set_inputs(id, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    if (id == 0) rst_a = 1'b0; else rst_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_inst, r_pc;
    logic        r_v, r_s;
    logic [2:0]  r_f;
    int          r;

    n_checks = 0;
    n_pass   = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    set_inputs(0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
    set_inputs(1, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);

    // ECALL after 16 addi retires.
    do_reset(0, "rst_a");
    for (int i = 0; i < 16; i++) drive(0, "ecall_pre", I_ADDI, 32'(i * 4), 1'b1, 1'b0, 3'b000);
    drive(0, "ecall_ev", I_ECALL, 32'h40, 1'b1, 1'b0, 3'b000);
    check("ecall.cause", o_cause, 64'd1);
    check("ecall.pc", o_pc, 64'h40);
    check("ecall.instret", o_ret, 64'd17);
    check("ecall.cycle", o_cyc, 64'd17);
    check("ecall.req_next", o_req, 64'd1);
    check("ecall.done_e0", o_done, 64'd0);
    idle(0, "ecall_d1");
    check("ecall.done_e1", o_done, 64'd0);
    idle(0, "ecall_d2");
    check("ecall.done_e2", o_done, 64'd0);
    idle(0, "ecall_d3");
    check("ecall.done_e3", o_done, 64'd1);
    drive(0, "ecall_ignore", I_EBREAK, 32'h99, 1'b1, 1'b0, 3'b011);
    check("ecall.held_cause", o_cause, 64'd1);

    // Fault coinciding with ECALL wins and the ECALL is not retired.
    do_reset(0, "rst_f");
    drive(0, "flt_pre", I_ADDI, 32'h0, 1'b1, 1'b0, 3'b000);
    drive(0, "flt_pre", I_ADDI, 32'h4, 1'b1, 1'b0, 3'b000);
    drive(0, "flt_ev", I_ECALL, 32'h8, 1'b1, 1'b0, 3'b100);
    check("fault.cause", o_cause, 64'd3);
    check("fault.vec", o_fv, 64'h4);
    check("fault.instret", o_ret, 64'd2);

    // Timeout with the core permanently stalled.
    do_reset(0, "rst_t");
    for (int i = 0; i < 49; i++) drive(0, "to_run", I_ADDI, 32'h0, 1'b1, 1'b1, 3'b000);
    check("timeout.not_yet", o_cause, 64'd0);
    drive(0, "to_ev", I_ADDI, 32'h0, 1'b1, 1'b1, 3'b000);
    check("timeout.cause", o_cause, 64'd4);
    check("timeout.cycle", o_cyc, 64'd50);
    check("timeout.instret", o_ret, 64'd0);

    // Self-loop at 0x20, interleaved with stalls.
    do_reset(0, "rst_l");
    for (int i = 0; i < 4; i++) drive(0, "loop_pre", I_ADDI, 32'(32'h10 + i * 4), 1'b1, 1'b0, 3'b000);
    drive(0, "loop_r1", I_JAL, 32'h20, 1'b1, 1'b0, 3'b000);
    drive(0, "loop_s", I_JAL, 32'h20, 1'b1, 1'b1, 3'b000);
    drive(0, "loop_r2", I_JAL, 32'h20, 1'b1, 1'b0, 3'b000);
    drive(0, "loop_s", I_JAL, 32'h20, 1'b1, 1'b1, 3'b000);
    drive(0, "loop_s", I_JAL, 32'h20, 1'b1, 1'b1, 3'b000);
    drive(0, "loop_r3", I_JAL, 32'h20, 1'b1, 1'b0, 3'b000);
    check("loop.not_yet", o_req, 64'd0);
    drive(0, "loop_r4", I_JAL, 32'h20, 1'b1, 1'b0, 3'b000);
    check("loop.cause", o_cause, 64'd5);
    check("loop.pc", o_pc, 64'h20);

    // Zero drain and 4-bit saturation.
    do_reset(1, "rst_b");
    for (int i = 0; i < 20; i++) drive(1, "sat_pre", I_ADDI, 32'(i * 4), 1'b1, 1'b0, 3'b000);
    drive(1, "sat_ev", I_ECALL, 32'h50, 1'b1, 1'b0, 3'b000);
    check("sat.instret", o_ret, 64'd15);
    check("sat.cycle", o_cyc, 64'd15);
    check("sat.done_e0", o_done, 64'd0);
    idle(1, "sat_d1");
    check("sat.done_e1", o_done, 64'd1);

    // Asynchronous reset in the middle of DRAIN.
    do_reset(0, "rst_m");
    drive(0, "mid_pre", I_ADDI, 32'h0c, 1'b1, 1'b0, 3'b000);
    drive(0, "mid_ev", I_EBREAK, 32'h10, 1'b1, 1'b0, 3'b000);
    check("mid.cause", o_cause, 64'd2);
    idle(0, "mid_drain");
    do_reset(0, "mid_rst");
    check("mid.req_cleared", o_req, 64'd0);
    check("mid.cause_cleared", o_cause, 64'd0);
    drive(0, "mid_new", I_ECALL, 32'h30, 1'b1, 1'b0, 3'b000);
    check("mid.new_cause", o_cause, 64'd1);
    check("mid.new_cycle", o_cyc, 64'd1);

    // Randomized runs on both instances.
    for (int t = 0; t < 12; t++) begin
      do_reset(t % 2, "rnd_rst");
      for (int c = 0; c < 60; c++) begin
        r = int'($urandom_range(0, 99));
        r_inst = (r < 4) ? I_ECALL : (r < 7) ? I_EBREAK : (r < 10) ? I_WFI : (r < 45) ? I_JAL : I_ADDI;
        r_pc   = 32'h100 + 32'(4 * $urandom_range(0, 2));
        r_v    = ($urandom_range(0, 3) != 0);
        r_s    = ($urandom_range(0, 3) == 0);
        r_f    = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        drive(t % 2, $sformatf("rnd%0d", t), r_inst, r_pc, r_v, r_s, r_f);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
